// File: rtl/speckv_csr_hub.sv
// speckv_csr_hub: MMIO control/status hub sitting between the host port and the SpecKV DMA channels.
// Holds per-channel saturating completion counters with threshold interrupts, and a host-fed descriptor FIFO.
module speckv_csr_hub #(
    parameter int NUM_CH     = 4,
    parameter int ADDR_W     = 16,
    parameter int CNT_W      = 32,
    parameter int DESC_W     = 128,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic [ADDR_W-1:0]                               mmio_addr,
    input  logic                                            mmio_wr_en,
    input  logic [63:0]                                     mmio_wr_data,
    input  logic                                            mmio_rd_en,
    output logic [63:0]                                     mmio_rd_data,
    output logic                                            mmio_rd_valid,
    input  logic [NUM_CH-1:0]                               done_valid,
    input  logic [NUM_CH*8-1:0]                             done_count,
    output logic                                            desc_valid,
    input  logic                                            desc_ready,
    output logic [DESC_W-1:0]                               desc_data,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]  desc_ch,
    output logic [NUM_CH-1:0]                               ch_enable,
    output logic                                            irq
);
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LVL_W  = PTR_W + 1;
    localparam int WORD_W = ADDR_W - 3;

    localparam logic [WORD_W-1:0] W_CTRL    = WORD_W'(0);
    localparam logic [WORD_W-1:0] W_STATUS  = WORD_W'(1);
    localparam logic [WORD_W-1:0] W_PEND    = WORD_W'(2);
    localparam logic [WORD_W-1:0] W_MASK    = WORD_W'(3);
    localparam logic [WORD_W-1:0] W_DESC_LO = WORD_W'(4);
    localparam logic [WORD_W-1:0] W_DESC_HI = WORD_W'(5);
    localparam logic [WORD_W-1:0] W_DESC_CH = WORD_W'(6);

    logic [NUM_CH-1:0] ch_en;
    logic [NUM_CH-1:0] irq_pending;
    logic [NUM_CH-1:0] irq_mask;
    logic [NUM_CH-1:0] pend_nxt;
    logic              overflow;
    logic [63:0]       desc_lo;
    logic [CH_W-1:0]   desc_ch_reg;

    logic [CNT_W-1:0]  cnt      [NUM_CH];
    logic [CNT_W-1:0]  thresh   [NUM_CH];
    logic [CNT_W-1:0]  cnt_base [NUM_CH];
    logic [CNT_W:0]    cnt_sum  [NUM_CH];
    logic [CNT_W-1:0]  cnt_nxt  [NUM_CH];
    logic [NUM_CH-1:0] cnt_clr;
    logic [NUM_CH-1:0] thr_wr;
    logic [NUM_CH-1:0] cnt_hit;
    logic [NUM_CH-1:0] thr_cross;

    logic [DESC_W-1:0] fifo_data [FIFO_DEPTH];
    logic [CH_W-1:0]   fifo_tag  [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              push_req;
    logic              push_ok;
    logic              push_drop;

    logic [WORD_W-1:0] word;
    logic              in_ch_region;
    logic [3:0]        slot;
    logic              slot_hi;
    logic              unused_addr_bits;
    logic              wr_ctrl;
    logic              ctrl_clr;
    logic              wr_pend;
    logic              wr_mask;
    logic              wr_lo;
    logic              wr_dch;
    logic [63:0]       rd_mux;

    // Channel slots live at 0x100..0x1FF: 16 bytes per channel, COUNT then THRESH.
    assign word             = mmio_addr[ADDR_W-1:3];
    assign in_ch_region     = (mmio_addr[ADDR_W-1:9] == '0) && mmio_addr[8];
    assign slot             = mmio_addr[7:4];
    assign slot_hi          = mmio_addr[3];
    assign unused_addr_bits = ^mmio_addr[2:0];

    assign wr_ctrl  = mmio_wr_en && (word == W_CTRL);
    assign ctrl_clr = wr_ctrl && mmio_wr_data[63];
    assign wr_pend  = mmio_wr_en && (word == W_PEND);
    assign wr_mask  = mmio_wr_en && (word == W_MASK);
    assign wr_lo    = mmio_wr_en && (word == W_DESC_LO);
    assign wr_dch   = mmio_wr_en && (word == W_DESC_CH);
    assign push_req = mmio_wr_en && (word == W_DESC_HI);

    // A clear collapses the old value to zero before the completion is added, so a same-cycle done is kept.
    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            cnt_clr[ch]   = ctrl_clr || (mmio_wr_en && in_ch_region && (slot == 4'(ch)) && !slot_hi);
            thr_wr[ch]    = mmio_wr_en && in_ch_region && (slot == 4'(ch)) && slot_hi;
            cnt_hit[ch]   = done_valid[ch] && ch_en[ch];
            cnt_base[ch]  = cnt_clr[ch] ? '0 : cnt[ch];
            cnt_sum[ch]   = {1'b0, cnt_base[ch]} + (CNT_W+1)'(done_count[8*ch +: 8]);
            cnt_nxt[ch]   = cnt_base[ch];
            if (cnt_hit[ch]) begin
                cnt_nxt[ch] = cnt_sum[ch][CNT_W] ? '1 : cnt_sum[ch][CNT_W-1:0];
            end
            thr_cross[ch] = cnt_hit[ch] && (thresh[ch] != '0) &&
                            (cnt_base[ch] < thresh[ch]) && (thresh[ch] <= cnt_nxt[ch]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                cnt[ch]    <= '0;
                thresh[ch] <= '0;
            end
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                cnt[ch] <= cnt_nxt[ch];
                if (thr_wr[ch]) begin
                    thresh[ch] <= mmio_wr_data[CNT_W-1:0];
                end
            end
        end
    end

    // A threshold crossing in the same cycle as a W1C or global clear still latches.
    always_comb begin
        pend_nxt = irq_pending;
        if (wr_pend) begin
            pend_nxt = pend_nxt & ~mmio_wr_data[NUM_CH-1:0];
        end
        if (ctrl_clr) begin
            pend_nxt = '0;
        end
        pend_nxt = pend_nxt | thr_cross;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_en       <= '0;
            irq_pending <= '0;
            irq_mask    <= '0;
            overflow    <= 1'b0;
            desc_lo     <= '0;
            desc_ch_reg <= '0;
        end else begin
            irq_pending <= pend_nxt;
            if (wr_ctrl) begin
                ch_en <= mmio_wr_data[NUM_CH-1:0];
            end
            if (wr_mask) begin
                irq_mask <= mmio_wr_data[NUM_CH-1:0];
            end
            if (wr_lo) begin
                desc_lo <= mmio_wr_data;
            end
            if (wr_dch) begin
                desc_ch_reg <= mmio_wr_data[CH_W-1:0];
            end
            if (push_drop) begin
                overflow <= 1'b1;
            end else if (wr_pend && mmio_wr_data[16]) begin
                overflow <= 1'b0;
            end
        end
    end

    // A push into a full FIFO is still accepted when the head leaves in the same cycle.
    assign fifo_full  = (level == LVL_W'(FIFO_DEPTH));
    assign fifo_empty = (level == '0);
    assign pop        = !fifo_empty && desc_ready;
    assign push_ok    = push_req && (!fifo_full || pop);
    assign push_drop  = push_req && !push_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level <= level + LVL_W'(push_ok) - LVL_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_data[wr_ptr] <= {mmio_wr_data, desc_lo};
            fifo_tag[wr_ptr]  <= desc_ch_reg;
        end
    end

    assign desc_valid = !fifo_empty;
    assign desc_data  = fifo_data[rd_ptr];
    assign desc_ch    = fifo_tag[rd_ptr];
    assign ch_enable  = ch_en;
    assign irq        = |(irq_pending & irq_mask);

    // Read mux sees pre-write register values, so a same-cycle write is not visible to the read.
    always_comb begin
        rd_mux = '0;
        if (in_ch_region) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (slot == 4'(ch)) begin
                    rd_mux = slot_hi ? 64'(thresh[ch]) : 64'(cnt[ch]);
                end
            end
        end else begin
            case (word)
                W_CTRL:    rd_mux[NUM_CH-1:0] = ch_en;
                W_STATUS: begin
                    rd_mux[7:0]         = 8'(level);
                    rd_mux[8]           = fifo_full;
                    rd_mux[9]           = fifo_empty;
                    rd_mux[10]          = overflow;
                    rd_mux[16 +: NUM_CH] = irq_pending;
                end
                W_PEND: begin
                    rd_mux[NUM_CH-1:0] = irq_pending;
                    rd_mux[16]         = overflow;
                end
                W_MASK:    rd_mux[NUM_CH-1:0] = irq_mask;
                W_DESC_CH: rd_mux[CH_W-1:0]   = desc_ch_reg;
                default:   rd_mux = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mmio_rd_data  <= '0;
            mmio_rd_valid <= 1'b0;
        end else begin
            mmio_rd_valid <= mmio_rd_en;
            if (mmio_rd_en) begin
                mmio_rd_data <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_speckv_csr_hub.sv
// tb_speckv_csr_hub: directed and randomized checks of speckv_csr_hub (NUM_CH=4, CNT_W=8, FIFO_DEPTH=8)
// against a queue/array reference model of the register map, counters, interrupts and FIFO.
module tb_speckv_csr_hub;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [15:0]  mmio_addr = '0;
    logic         mmio_wr_en = 1'b0;
    logic [63:0]  mmio_wr_data = '0;
    logic         mmio_rd_en = 1'b0;
    logic [63:0]  mmio_rd_data;
    logic         mmio_rd_valid;
    logic [3:0]   done_valid = '0;
    logic [31:0]  done_count = '0;
    logic         desc_valid;
    logic         desc_ready = 1'b0;
    logic [127:0] desc_data;
    logic [1:0]   desc_ch;
    logic [3:0]   ch_enable;
    logic         irq;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        logic [127:0] data;
        logic [1:0]   ch;
    } desc_t;

    desc_t       m_q[$];
    int          m_cnt [4];
    int          m_thr [4];
    logic [3:0]  m_en, m_pend, m_mask;
    logic        m_ovf;
    logic [63:0] m_lo;
    logic [1:0]  m_dch;
    logic [63:0] m_rd_last;

    logic [15:0] wr_pool [18] = '{16'h000, 16'h010, 16'h018, 16'h020, 16'h028, 16'h028,
                                  16'h028, 16'h030, 16'h100, 16'h110, 16'h120, 16'h130,
                                  16'h108, 16'h118, 16'h128, 16'h138, 16'h148, 16'h038};
    logic [15:0] rd_pool [13] = '{16'h000, 16'h008, 16'h008, 16'h018, 16'h030, 16'h100,
                                  16'h110, 16'h120, 16'h130, 16'h108, 16'h138, 16'h140, 16'h038};

    speckv_csr_hub #(
        .NUM_CH(4), .ADDR_W(16), .CNT_W(8), .DESC_W(128), .FIFO_DEPTH(8)
    ) dut (
        .clk(clk), .rst(rst),
        .mmio_addr(mmio_addr), .mmio_wr_en(mmio_wr_en), .mmio_wr_data(mmio_wr_data),
        .mmio_rd_en(mmio_rd_en), .mmio_rd_data(mmio_rd_data), .mmio_rd_valid(mmio_rd_valid),
        .done_valid(done_valid), .done_count(done_count),
        .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_data(desc_data), .desc_ch(desc_ch),
        .ch_enable(ch_enable), .irq(irq)
    );

    always #5 clk = ~clk;

    // Bound the whole run in case something stalls the stimulus.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void modelReset();
        m_q.delete();
        for (int i = 0; i < 4; i++) begin
            m_cnt[i] = 0;
            m_thr[i] = 0;
        end
        m_en = '0; m_pend = '0; m_mask = '0; m_ovf = 1'b0;
        m_lo = '0; m_dch = '0; m_rd_last = '0;
    endfunction

    function automatic bit inChRegion(input logic [15:0] a);
        return (a >= 16'h100) && (a < 16'h200);
    endfunction

    function automatic bit isReadable(input logic [15:0] a);
        return (a == 16'h000) || (a == 16'h008) || (a == 16'h018) || (a == 16'h030) ||
               (a == 16'h038) || inChRegion(a);
    endfunction

    function automatic logic [63:0] modelRead(input logic [15:0] a);
        logic [63:0] r;
        int slot;
        r = '0;
        if (inChRegion(a)) begin
            slot = int'((a >> 4) & 16'hF);
            if (slot < 4) r = a[3] ? 64'(m_thr[slot]) : 64'(m_cnt[slot]);
        end else begin
            case (int'(a >> 3))
                0: r = 64'(m_en);
                1: begin
                    r = 64'(m_q.size());
                    r[8]     = (m_q.size() == 8);
                    r[9]     = (m_q.size() == 0);
                    r[10]    = m_ovf;
                    r[19:16] = m_pend;
                end
                3: r = 64'(m_mask);
                6: r = 64'(m_dch);
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    // One clock cycle: drive inputs, advance the model, then compare all visible outputs after the edge.
    task automatic applyStimulus(input bit wr, input bit rd, input logic [15:0] a, input logic [63:0] wd,
                                 input logic [3:0] dv, input logic [31:0] dc, input bit rdy);
        logic [63:0] exp_rd;
        bit in_ch, hi, ctrl_clr, pop, push;
        int w, slot, base, nv;
        logic [3:0] setb;
        desc_t d;

        mmio_addr = a; mmio_wr_en = wr; mmio_wr_data = wd; mmio_rd_en = rd;
        done_valid = dv; done_count = dc; desc_ready = rdy;

        exp_rd   = modelRead(a);
        in_ch    = inChRegion(a);
        w        = int'(a >> 3);
        slot     = int'((a >> 4) & 16'hF);
        hi       = a[3];
        ctrl_clr = wr && !in_ch && (w == 0) && wd[63];
        setb     = '0;
        for (int ch = 0; ch < 4; ch++) begin
            base = m_cnt[ch];
            if (ctrl_clr || (wr && in_ch && slot == ch && !hi)) base = 0;
            if (dv[ch] && m_en[ch]) begin
                nv = base + int'(dc[8*ch +: 8]);
                if (nv > 255) nv = 255;
                if (m_thr[ch] != 0 && base < m_thr[ch] && m_thr[ch] <= nv) setb[ch] = 1'b1;
                m_cnt[ch] = nv;
            end else begin
                m_cnt[ch] = base;
            end
        end
        if (wr && !in_ch && w == 2) begin
            m_pend = m_pend & ~wd[3:0];
            if (wd[16]) m_ovf = 1'b0;
        end
        if (ctrl_clr) m_pend = '0;
        m_pend = m_pend | setb;

        pop  = rdy && (m_q.size() > 0);
        push = wr && !in_ch && (w == 5);
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (m_q.size() < 8) begin
                d.data = {wd, m_lo};
                d.ch   = m_dch;
                m_q.push_back(d);
            end else begin
                m_ovf = 1'b1;
            end
        end
        if (wr && !in_ch) begin
            case (w)
                0: m_en   = wd[3:0];
                3: m_mask = wd[3:0];
                4: m_lo   = wd;
                6: m_dch  = wd[1:0];
                default: ;
            endcase
        end
        if (wr && in_ch && slot < 4 && hi) m_thr[slot] = int'(wd[7:0]);
        if (rd) m_rd_last = exp_rd;

        @(posedge clk);
        #1;
        checkOutput("rd_valid", 128'(mmio_rd_valid), 128'(rd));
        checkOutput($sformatf("rd_data@%0h", a), 128'(mmio_rd_data), 128'(m_rd_last));
        checkOutput("irq", 128'(irq), 128'(|(m_pend & m_mask)));
        checkOutput("ch_enable", 128'(ch_enable), 128'(m_en));
        checkOutput("desc_valid", 128'(desc_valid), 128'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            checkOutput("desc_data", desc_data, m_q[0].data);
            checkOutput("desc_ch", 128'(desc_ch), 128'(m_q[0].ch));
        end

        mmio_wr_en = 1'b0; mmio_rd_en = 1'b0; done_valid = '0; done_count = '0; desc_ready = 1'b0;
    endtask

    task automatic mmioWrite(input logic [15:0] a, input logic [63:0] wd);
        applyStimulus(1'b1, 1'b0, a, wd, 4'h0, 32'h0, 1'b0);
    endtask

    task automatic mmioRead(input logic [15:0] a);
        applyStimulus(1'b0, 1'b1, a, 64'h0, 4'h0, 32'h0, 1'b0);
    endtask

    task automatic pushDesc(input int i);
        mmioWrite(16'h030, 64'(i % 4));
        mmioWrite(16'h020, 64'h0000_A000 + 64'(i));
        mmioWrite(16'h028, 64'h0000_B000 + 64'(i));
    endtask

    initial begin
        bit wr, rd, rdy;
        logic [15:0] a;
        logic [63:0] wd;
        logic [3:0]  dv;
        logic [31:0] dc;
        int kind;

        modelReset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("reset_rd_valid", 128'(mmio_rd_valid), 128'(0));
        checkOutput("reset_rd_data", 128'(mmio_rd_data), 128'(0));
        checkOutput("reset_desc_valid", 128'(desc_valid), 128'(0));
        checkOutput("reset_ch_enable", 128'(ch_enable), 128'(0));
        checkOutput("reset_irq", 128'(irq), 128'(0));
        mmioRead(16'h008);
        checkOutput("status_after_reset", 128'(mmio_rd_data), 128'h200);

        // Threshold crossing raises irq; W1C drops it.
        mmioWrite(16'h000, 64'h3);
        mmioWrite(16'h118, 64'd10);
        mmioWrite(16'h018, 64'h2);
        applyStimulus(1'b0, 1'b0, 16'h0, 64'h0, 4'b0010, 32'h0000_0600, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0, 64'h0, 4'b0010, 32'h0000_0600, 1'b0);
        mmioRead(16'h110);
        checkOutput("count1_twelve", 128'(mmio_rd_data), 128'd12);
        checkOutput("irq_set", 128'(irq), 128'(1));
        mmioWrite(16'h010, 64'h2);
        checkOutput("irq_cleared", 128'(irq), 128'(0));

        // Saturation at 2^8-1 and disabled channel ignoring completions.
        mmioWrite(16'h100, 64'h0);
        applyStimulus(1'b0, 1'b0, 16'h0, 64'h0, 4'b0001, 32'd250, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0, 64'h0, 4'b0001, 32'd20, 1'b0);
        mmioRead(16'h100);
        checkOutput("count0_saturated", 128'(mmio_rd_data), 128'd255);
        applyStimulus(1'b0, 1'b0, 16'h0, 64'h0, 4'b0100, 32'h0009_0000, 1'b0);
        mmioRead(16'h120);
        checkOutput("count2_disabled", 128'(mmio_rd_data), 128'd0);

        // Clear and completion in the same cycle keep the completion.
        applyStimulus(1'b1, 1'b0, 16'h100, 64'h0, 4'b0001, 32'd5, 1'b0);
        mmioRead(16'h100);
        checkOutput("count0_clear_with_done", 128'(mmio_rd_data), 128'd5);

        // Overfill the FIFO, then drain in order.
        mmioWrite(16'h000, 64'h8000_0000_0000_0003);
        for (int i = 1; i <= 9; i++) pushDesc(i);
        mmioRead(16'h008);
        checkOutput("status_full_ovf", 128'(mmio_rd_data), 128'h508);
        for (int i = 1; i <= 8; i++) begin
            checkOutput($sformatf("drain_data%0d", i), desc_data,
                        {64'h0000_B000 + 64'(i), 64'h0000_A000 + 64'(i)});
            checkOutput($sformatf("drain_ch%0d", i), 128'(desc_ch), 128'(i % 4));
            applyStimulus(1'b0, 1'b0, 16'h0, 64'h0, 4'h0, 32'h0, 1'b1);
        end
        checkOutput("drained_empty", 128'(desc_valid), 128'(0));

        // Asynchronous reset with entries still queued.
        for (int i = 0; i < 5; i++) pushDesc(i);
        applyStimulus(1'b0, 1'b0, 16'h0, 64'h0, 4'h0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 16'h0, 64'h0, 4'h0, 32'h0, 1'b1);
        checkOutput("three_queued_valid", 128'(desc_valid), 128'(1));
        rst = 1'b1;
        #1;
        checkOutput("async_reset_desc_valid", 128'(desc_valid), 128'(0));
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mmioRead(16'h008);
        checkOutput("status_after_midreset", 128'(mmio_rd_data), 128'h200);
        checkOutput("ch_enable_after_midreset", 128'(ch_enable), 128'(0));

        // Randomized traffic against the model.
        mmioWrite(16'h000, 64'hF);
        for (int it = 0; it < 3000; it++) begin
            wr = 1'b0; rd = 1'b0; a = '0;
            wd = {$urandom, $urandom};
            kind = int'($urandom_range(0, 9));
            if (kind < 5) begin
                wr = 1'b1;
                a  = wr_pool[$urandom_range(0, 17)];
                if (a == 16'h000) begin
                    wd = 64'($urandom_range(0, 15));
                    if ($urandom_range(0, 7) == 0) wd[63] = 1'b1;
                end else if (a == 16'h010) begin
                    wd = 64'($urandom_range(0, 15));
                    wd[16] = ($urandom_range(0, 1) == 1);
                end else if (a == 16'h018) begin
                    wd = 64'($urandom_range(0, 15));
                end else if (a == 16'h030) begin
                    wd = 64'($urandom_range(0, 3));
                end else if (inChRegion(a) && a[3]) begin
                    wd = 64'($urandom_range(0, 40));
                end
                rd = isReadable(a) && ($urandom_range(0, 3) == 0);
            end else if (kind < 8) begin
                rd = 1'b1;
                a  = rd_pool[$urandom_range(0, 12)];
            end
            dv = 4'($urandom_range(0, 15));
            for (int b = 0; b < 4; b++) begin
                dc[8*b +: 8] = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255))
                                                            : 8'($urandom_range(0, 12));
            end
            rdy = ($urandom_range(0, 5) == 0);
            applyStimulus(wr, rd, a, wd, dv, dc, rdy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/speckv_csr_hub.md
Name: speckv_csr_hub

Overview:
Multi-channel MMIO control/status hub for the SpecKV accelerator. It generalises the single status/completion register pair to NUM_CH independent DMA channels. Each channel has a saturating completion counter, a threshold interrupt and an enable bit. A host-fed descriptor FIFO issues tagged descriptors to the DMA channels. The block sits between the host MMIO port and the per-channel dma_engine instances inside the accelerator top level.

Parameters:
NUM_CH, 4, number of DMA channels (1..16)
ADDR_W, 16, MMIO byte-address width
CNT_W, 32, completion counter width
DESC_W, 128, descriptor width (fixed two 64-bit halves)
FIFO_DEPTH, 8, descriptor FIFO entries (power of two)

Ports:
clk  in  1  sole clock
rst  in  1  asynchronous, active-high reset
mmio_addr  in  ADDR_W  byte address, 8-byte aligned (bits[2:0] ignored)
mmio_wr_en  in  1  write strobe, single cycle
mmio_wr_data  in  64  write data
mmio_rd_en  in  1  read strobe, single cycle
mmio_rd_data  out  64  read data, valid with mmio_rd_valid
mmio_rd_valid  out  1  one-cycle pulse, 1 cycle after mmio_rd_en
done_valid  in  NUM_CH  per-channel completion strobe
done_count  in  NUM_CH*8  per-channel completed count, byte ch at [8ch+7:8ch]
desc_valid  out  1  FIFO head valid
desc_ready  in  1  consumer accepts head
desc_data  out  DESC_W  head descriptor {hi,lo}
desc_ch  out  $clog2(NUM_CH) (min 1)  head channel tag
ch_enable  out  NUM_CH  per-channel enable
irq  out  1  level interrupt = |(irq_pending & irq_mask)

Behaviour:
- Reset (async assert, sync release):
  - all registers 0, FIFO empty
  - outputs: mmio_rd_data=0, mmio_rd_valid=0, desc_valid=0, ch_enable=0, irq=0
- Register map (offsets):
  - 0x000 CTRL RW: [NUM_CH-1:0]=ch_enable. Writing bit63=1 clears all counters and pending bits; bit63 is self-clearing and reads 0.
  - 0x008 STATUS RO: [7:0]=FIFO level, [8]=full, [9]=empty, [10]=overflow sticky, [31:16]=irq_pending.
  - 0x010 IRQ_PENDING W1C; writing bit 16 clears overflow.
  - 0x018 IRQ_MASK RW.
  - 0x020 DESC_LO WO staging; 0x030 DESC_CH RW.
  - 0x028 DESC_HI: a write pushes {wr_data, DESC_LO} tagged with DESC_CH[low bits]. DESC_LO is not cleared by the push.
  - 0x100+ch*0x10 COUNT[ch]: RO value; any write clears the counter.
  - 0x108+ch*0x10 THRESH[ch] RW (CNT_W bits).
  - Unmapped addresses, and channel slots >= NUM_CH: reads return 0, writes are ignored.
- Read path:
  - registered, latency 1. mmio_rd_data holds its value until the next read.
  - Read and write to the same address in one cycle: the read returns the pre-write value.
- Counters:
  - on done_valid[ch] with ch_enable[ch]=1: cnt <= min(cnt + done_count, 2^CNT_W - 1), saturating.
  - done_valid on a disabled channel is ignored.
  - clear (COUNT write or CTRL bit63) in the same cycle as done: cnt <= done_count, so no completion is lost.
- Interrupt:
  - pending[ch] sets when THRESH != 0 and old_cnt < THRESH <= new_cnt.
  - set wins over a same-cycle W1C; only the crossing edge sets it.
  - irq is combinational from the pending and mask registers.
- FIFO:
  - push and pop in the same cycle are allowed when not empty.
  - push when full: descriptor dropped, overflow sticky set, level unchanged.
  - push+pop when full: push accepted.
  - desc_data and desc_ch are stable while desc_valid=1 and desc_ready=0. Pointers wrap modulo FIFO_DEPTH.
- Reset mid-operation: FIFO contents discarded, desc_valid drops asynchronously.

Test Plan:
- Reset then read 0x008 -> mmio_rd_valid one cycle later, data = 0x200 (empty=1, level 0).
- CTRL=0x3, THRESH[1]=10, IRQ_MASK=0x2; done_count[1]=6 twice -> COUNT[1]=12, pending[1]=1, irq=1; W1C 0x2 -> irq=0.
- With CNT_W=8: load 250, then done_count=20 -> COUNT reads 255. A done pulse on disabled channel 2 -> COUNT[2] stays 0.
- COUNT[0] write-clear in the same cycle as done_count[0]=5 -> COUNT[0]=5.
- Push 9 descriptors with desc_ready=0, FIFO_DEPTH=8 -> level 8, full=1, overflow=1, 9th dropped. Drain -> descriptors 1..8 in order with correct desc_ch.
- Assert rst mid-drain with 3 entries queued -> desc_valid=0 immediately. After release, STATUS=0x200 and ch_enable=0.
